// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM state encoding and branch condition codes.
// The condition codes are also used by the decoder that produces br_cond.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StExec,
        StHalt
    } state_e;

    localparam logic [2:0] CondNever  = 3'b000;
    localparam logic [2:0] CondGe     = 3'b001;
    localparam logic [2:0] CondGeAlt  = 3'b010;
    localparam logic [2:0] CondEqz    = 3'b011;
    localparam logic [2:0] CondAlways = 3'b100;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of imem, decode and execute-side signals around the PC sequencer.
// master is the sequencer's view; slave is the surrounding pipeline's view.
interface pc_sequencer_if #(
    parameter int unsigned N = 32
);
    logic          imem_req;
    logic [N-1:0]  imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          ir_valid;
    logic [31:0]   ir;
    logic [N-1:0]  ir_pc;
    logic          ir_ready;
    logic          br_valid;
    logic [2:0]    br_cond;
    logic [N-1:0]  br_a;
    logic [N-1:0]  br_target;
    logic          halt;
    logic [N-1:0]  pc;
    logic          br_taken;
    logic          halted;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc, pc, br_taken, halted,
        input  imem_ack, imem_rdata, ir_ready, br_valid, br_cond, br_a, br_target, halt
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc, pc, br_taken, halted,
        output imem_ack, imem_rdata, ir_ready, br_valid, br_cond, br_a, br_target, halt
    );

endinterface

// File: rtl/pc_sequencer_branch_eval.sv
// Combinational branch condition evaluator: (br_a, br_cond) -> taken.
module pc_sequencer_branch_eval
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] br_a,
    input  logic [2:0]   br_cond,
    output logic         taken
);

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            CondGe, CondGeAlt: taken = ~br_a[N-1];
            CondEqz:           taken = (br_a == '0);
            CondAlways:        taken = 1'b1;
            default:           taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/branch sequencer: owns the PC, fetches one instruction at a time,
// hands it to decode, then picks the next PC once execute resolves it.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] PC_INC   = N'(4)
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.master bus
);

    // Taken targets are forced onto an instruction boundary.
    localparam logic [N-1:0] AlignMask = ~(PC_INC - N'(1));

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] ir_pc_q, ir_pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         br_taken_q, br_taken_d;
    logic         taken;

    pc_sequencer_branch_eval #(
        .N(N)
    ) u_branch_eval (
        .br_a   (bus.br_a),
        .br_cond(bus.br_cond),
        .taken  (taken)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        br_taken_d = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    ir_pc_d = pc_q;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.ir_ready) state_d = StExec;
            end
            StExec: begin
                if (bus.br_valid) begin
                    // halt beats any branch outcome and leaves pc untouched
                    if (bus.halt) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StFetch;
                        if (taken) begin
                            pc_d       = bus.br_target & AlignMask;
                            br_taken_d = 1'b1;
                        end else begin
                            pc_d = pc_q + PC_INC;
                        end
                    end
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign bus.imem_req  = (state_q == StFetch);
    assign bus.imem_addr = pc_q;
    assign bus.ir_valid  = (state_q == StIssue);
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.pc        = pc_q;
    assign bus.br_taken  = br_taken_q;
    assign bus.halted    = (state_q == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: fetch, branch conditions, back-pressure,
// PC wrap/alignment, halt and mid-fetch reset.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.N(32)) bus ();

    pc_sequencer #(
        .N       (32),
        .RESET_PC(32'h0),
        .PC_INC  (32'h4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a request at addr, optionally stall the ack, then deliver instr.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input int ack_dly);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("req_seen", 32'(bus.imem_req), 32'd1);
        check_eq("imem_addr", bus.imem_addr, addr);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check_eq("req_held", 32'(bus.imem_req), 32'd1);
            check_eq("addr_held", bus.imem_addr, addr);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = instr;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        check_eq("ir_valid_up", 32'(bus.ir_valid), 32'd1);
        check_eq("ir", bus.ir, instr);
        check_eq("ir_pc", bus.ir_pc, addr);
        check_eq("req_drop", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] addr, input int rdy_dly);
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            check_eq("ir_valid_held", 32'(bus.ir_valid), 32'd1);
            check_eq("ir_stable", bus.ir, instr);
            check_eq("ir_pc_stable", bus.ir_pc, addr);
            check_eq("no_extra_req", 32'(bus.imem_req), 32'd0);
        end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        check_eq("ir_valid_drop", 32'(bus.ir_valid), 32'd0);
    endtask

    task automatic resolve(input logic [2:0] cond, input logic [31:0] a, input logic [31:0] tgt,
                           input logic hlt, input logic exp_taken, input logic [31:0] exp_pc);
        bus.br_valid  = 1'b1;
        bus.br_cond   = cond;
        bus.br_a      = a;
        bus.br_target = tgt;
        bus.halt      = hlt;
        tick();
        bus.br_valid = 1'b0;
        bus.halt     = 1'b0;
        check_eq("br_taken", 32'(bus.br_taken), 32'(exp_taken));
        check_eq("pc_next", bus.pc, exp_pc);
        check_eq("halted", 32'(bus.halted), 32'(hlt));
        check_eq("req_after_resolve", 32'(bus.imem_req), 32'(!hlt));
        if (exp_taken) begin
            tick();
            check_eq("br_taken_pulse_end", 32'(bus.br_taken), 32'd0);
        end
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.ir_ready   = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_cond    = 3'b000;
        bus.br_a       = 32'h0;
        bus.br_target  = 32'h0;
        bus.halt       = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("rst_ir", bus.ir, 32'h0);
        check_eq("rst_ir_pc", bus.ir_pc, 32'h0);
        check_eq("rst_pc", bus.pc, 32'h0);
        check_eq("rst_br_taken", 32'(bus.br_taken), 32'd0);
        check_eq("rst_halted", 32'(bus.halted), 32'd0);
        rst = 1'b0;

        // Sequential fetch, single-cycle ack, decode always ready
        fetch(32'h0, 32'h1111_0000, 0);
        issue(32'h1111_0000, 32'h0, 0);
        resolve(3'b000, 32'h0, 32'h400, 1'b0, 1'b0, 32'h4);
        fetch(32'h4, 32'h1111_0004, 0);
        issue(32'h1111_0004, 32'h4, 0);
        resolve(3'b000, 32'h0, 32'h400, 1'b0, 1'b0, 32'h8);
        fetch(32'h8, 32'h1111_0008, 0);
        issue(32'h1111_0008, 32'h8, 0);

        // br_a == 0 condition
        resolve(3'b011, 32'h0, 32'h40, 1'b0, 1'b1, 32'h40);
        fetch(32'h40, 32'h2222_0040, 0);
        issue(32'h2222_0040, 32'h40, 0);
        resolve(3'b011, 32'h5, 32'h80, 1'b0, 1'b0, 32'h44);

        // Sign conditions, alias and reserved codes
        fetch(32'h44, 32'h3333_0044, 0);
        issue(32'h3333_0044, 32'h44, 0);
        resolve(3'b001, 32'h8000_0000, 32'h100, 1'b0, 1'b0, 32'h48);
        fetch(32'h48, 32'h3333_0048, 0);
        issue(32'h3333_0048, 32'h48, 0);
        resolve(3'b001, 32'h7FFF_FFFF, 32'h100, 1'b0, 1'b1, 32'h100);
        fetch(32'h100, 32'h3333_0100, 0);
        issue(32'h3333_0100, 32'h100, 0);
        resolve(3'b110, 32'h0, 32'h200, 1'b0, 1'b0, 32'h104);
        fetch(32'h104, 32'h3333_0104, 0);
        issue(32'h3333_0104, 32'h104, 0);
        resolve(3'b010, 32'h1, 32'h200, 1'b0, 1'b1, 32'h200);
        fetch(32'h200, 32'h3333_0200, 0);
        issue(32'h3333_0200, 32'h200, 0);
        resolve(3'b111, 32'h0, 32'h300, 1'b0, 1'b0, 32'h204);

        // Back-pressure plus stray br_valid / ack outside their states
        fetch(32'h204, 32'h4444_0204, 3);
        bus.br_valid  = 1'b1;
        bus.br_cond   = 3'b100;
        bus.br_target = 32'h500;
        tick();
        bus.br_valid = 1'b0;
        check_eq("stray_br_pc", bus.pc, 32'h204);
        check_eq("stray_br_taken", 32'(bus.br_taken), 32'd0);
        check_eq("stray_br_ir_valid", 32'(bus.ir_valid), 32'd1);
        issue(32'h4444_0204, 32'h204, 2);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        check_eq("stray_ack_ir", bus.ir, 32'h4444_0204);
        check_eq("stray_ack_req", 32'(bus.imem_req), 32'd0);
        check_eq("stray_ack_ir_valid", 32'(bus.ir_valid), 32'd0);
        resolve(3'b100, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC);

        // PC wrap and target alignment
        fetch(32'hFFFF_FFFC, 32'h5555_FFFC, 0);
        issue(32'h5555_FFFC, 32'hFFFF_FFFC, 0);
        resolve(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        fetch(32'h0, 32'h5555_0000, 0);
        issue(32'h5555_0000, 32'h0, 0);
        resolve(3'b100, 32'h0, 32'h43, 1'b0, 1'b1, 32'h40);
        fetch(32'h40, 32'h5555_0040, 0);
        issue(32'h5555_0040, 32'h40, 0);
        resolve(3'b100, 32'h0, 32'h100, 1'b0, 1'b1, 32'h100);

        // Reset mid-fetch (req is high at 0x100), with an ack in the same cycle
        check_eq("pre_rst_req", 32'(bus.imem_req), 32'd1);
        rst            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        tick();
        rst = 1'b0;
        check_eq("midrst_req", 32'(bus.imem_req), 32'd0);
        check_eq("midrst_pc", bus.pc, 32'h0);
        check_eq("midrst_ir", bus.ir, 32'h0);
        check_eq("midrst_ir_valid", 32'(bus.ir_valid), 32'd0);
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        check_eq("stale_ack_ir", bus.ir, 32'h0);
        check_eq("stale_ack_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_eq("post_rst_req", 32'(bus.imem_req), 32'd1);

        // Halt beats an always-taken branch
        fetch(32'h0, 32'h6666_0000, 0);
        issue(32'h6666_0000, 32'h0, 0);
        resolve(3'b100, 32'h0, 32'h80, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            bus.br_valid = 1'b1;
            bus.imem_ack = 1'b1;
            tick();
        end
        bus.br_valid = 1'b0;
        bus.imem_ack = 1'b0;
        check_eq("halt_absorb", 32'(bus.halted), 32'd1);
        check_eq("halt_no_req", 32'(bus.imem_req), 32'd0);
        check_eq("halt_pc", bus.pc, 32'h0);
        check_eq("halt_br_taken", 32'(bus.br_taken), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("unhalt_by_rst", 32'(bus.halted), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
